gate_bist: RTL and testbench

- Parametrised built-in self-test engine for N-input combinational logic gates.
- On `start`, it walks every one of the 2^N_IN input vectors into an external gate under test and waits a programmable settle time for each.
- It compares the gate's output against an internal golden model for the selected operation, then reports pass/fail, an error count and the first failing vector.
- It sits beside the lab gate library (nor/nand/and/or/xor cells) and replaces per-gate hand-written stimulus.

---
 rtl/gate_pkg.sv | 34 +++
 rtl/gate_ref.sv | 12 +
 rtl/gate_bist.sv | 92 +++++++++
 tb/tb_gate_bist.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// gate_pkg: opcodes, FSM states and the golden gate model shared by RTL and benches.
package gate_pkg;
    localparam logic [2:0] OP_NOR  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    // Only the low n bits of vec take part; reserved opcodes fall back to NOR.
    function automatic logic gate_golden(input logic [2:0] op, input logic [7:0] vec, input int n);
        logic a, o, x;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                a = a & vec[i];
                o = o | vec[i];
                x = x ^ vec[i];
            end
        end
        case (op)
            OP_NAND: return ~a;
            OP_AND:  return a;
            OP_OR:   return o;
            OP_XOR:  return x;
            OP_XNOR: return ~x;
            default: return ~o;
        endcase
    endfunction
endpackage

// File: rtl/gate_ref.sv
// gate_ref: combinational reference gate, also usable as a known-good DUT.
module gate_ref
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      i_op,
    input  logic [N_IN-1:0] i_vec,
    output logic            o_y
);
    assign o_y = gate_golden(i_op, 8'(i_vec), N_IN);
endmodule

// File: rtl/gate_bist.sv
// gate_bist: exhaustive BIST sweep of an N_IN-input gate against a golden model.
// Optional GATE_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_bist
    import gate_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op_sel,
    output logic [N_IN-1:0] dut_a,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [2:0]        r_op;
    logic [N_IN-1:0]   r_a, r_fail;
    logic [N_IN:0]     r_err;
    logic              r_pass;
    logic              w_gold, w_mis, w_last;

    gate_ref #(.N_IN(N_IN)) u_ref (.i_op(r_op), .i_vec(r_a), .o_y(w_gold));

    // Case inequality so an X from the gate under test counts as a failure.
    assign w_mis  = (dut_y !== w_gold);
    assign w_last = &r_a;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_SETTLE : S_IDLE;
            S_SETTLE: w_next = (r_cnt == 4'd0) ? S_CHECK : S_SETTLE;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
            S_CHECK:  w_next = (w_last || w_mis) ? S_DONE : S_SETTLE;
`else
            S_CHECK:  w_next = w_last ? S_DONE : S_SETTLE;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op   <= op_sel;
                    r_a    <= '0;
                    r_err  <= '0;
                    r_fail <= '0;
                    r_pass <= 1'b0;
                    r_cnt  <= 4'(SETTLE_CYC - 1);
                end
                S_SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                S_CHECK: begin
                    if (w_mis) begin
                        r_err <= r_err + 1'b1;
                        if (r_err == '0) r_fail <= r_a;
                    end
                    if (w_next == S_SETTLE) begin
                        r_a   <= r_a + 1'b1;
                        r_cnt <= 4'(SETTLE_CYC - 1);
                    end
                    if (w_next == S_DONE) r_pass <= !w_mis && (r_err == '0);
                end
                default: ;
            endcase
        end
    end

    assign dut_a     = r_a;
    assign busy      = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed checks of gate_bist on three configurations with bench-modelled gates.
module tb_gate_bist;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    int n_tests = 0, n_fail = 0;

    // A: N_IN=2, SETTLE_CYC=1; gate chosen by a_mode (0 NOR, 1 AND, 2 stuck-at-0)
    logic a_start = 0, a_y, a_busy, a_done, a_pass;
    logic [2:0] a_op = 0, a_err;
    logic [1:0] a_dut_a, a_fail, a_mode = 0;
    // B: N_IN=4, SETTLE_CYC=3; XOR gate
    logic b_start = 0, b_y, b_busy, b_done, b_pass;
    logic [2:0] b_op = 0;
    logic [3:0] b_dut_a, b_fail;
    logic [4:0] b_err;
    // C: N_IN=1, SETTLE_CYC=1; inverter
    logic c_start = 0, c_y, c_busy, c_done, c_pass;
    logic [2:0] c_op = 0;
    logic [0:0] c_dut_a, c_fail;
    logic [1:0] c_err;

    assign a_y = (a_mode == 2'd0) ? ~(a_dut_a[0] | a_dut_a[1]) :
                 (a_mode == 2'd1) ? (a_dut_a[0] & a_dut_a[1]) : 1'b0;
    assign b_y = b_dut_a[0] ^ b_dut_a[1] ^ b_dut_a[2] ^ b_dut_a[3];
    assign c_y = ~c_dut_a[0];

    gate_bist #(.N_IN(2), .SETTLE_CYC(1)) u_a (.clk(clk), .rst_n(rst_n), .start(a_start), .op_sel(a_op),
        .dut_a(a_dut_a), .dut_y(a_y), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err), .fail_vec(a_fail));
    gate_bist #(.N_IN(4), .SETTLE_CYC(3)) u_b (.clk(clk), .rst_n(rst_n), .start(b_start), .op_sel(b_op),
        .dut_a(b_dut_a), .dut_y(b_y), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err), .fail_vec(b_fail));
    gate_bist #(.N_IN(1), .SETTLE_CYC(1)) u_c (.clk(clk), .rst_n(rst_n), .start(c_start), .op_sel(c_op),
        .dut_a(c_dut_a), .dut_y(c_y), .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err), .fail_vec(c_fail));

    always #5 clk = ~clk;

    // Pulses start on instance sel; returns the cycle done is seen in (first SETTLE = 1), -1 on timeout.
    task automatic run(input int sel, input logic [2:0] op, output int cyc);
        logic d;
        @(negedge clk);
        case (sel)
            0: begin a_op = op; a_start = 1'b1; end
            1: begin b_op = op; b_start = 1'b1; end
            default: begin c_op = op; c_start = 1'b1; end
        endcase
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        cyc = 1;
        d = (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
        while (!d && cyc < 400) begin
            @(negedge clk);
            cyc++;
            d = (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
        end
        if (!d) cyc = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (a_dut_a !== 2'd0) begin n_fail++; $display("FAIL reset_dut_a got %0d exp 0", a_dut_a); end
        n_tests++; if ({a_busy, a_done, a_pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {a_busy, a_done, a_pass}); end
        n_tests++; if (a_err !== 3'd0 || a_fail !== 2'd0) begin n_fail++; $display("FAIL reset_results got err=%0d fv=%0d exp 0/0", a_err, a_fail); end
        rst_n = 1'b1;
    endtask

    task automatic test_nor_good();
        int cyc;
        logic [1:0] seen [1:8];
        a_mode = 2'd0;
        @(negedge clk);
        a_op = 3'd0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 1;
        while (!a_done && cyc < 40) begin
            if (cyc <= 8) seen[cyc] = a_dut_a;
            n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL nor_busy cycle %0d got %b exp 1", cyc, a_busy); end
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (cyc !== 9) begin n_fail++; $display("FAIL nor_done_cycle got %0d exp 9", cyc); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (seen[2*k+1] !== k[1:0] || seen[2*k+2] !== k[1:0]) begin
                n_fail++; $display("FAIL nor_vec%0d got %0d,%0d exp %0d", k, seen[2*k+1], seen[2*k+2], k);
            end
        end
        n_tests++; if (a_pass !== 1'b1 || a_err !== 3'd0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL nor_result got pass=%b err=%0d busy=%b exp 1/0/0", a_pass, a_err, a_busy); end
        @(negedge clk);
        n_tests++; if (a_done !== 1'b0 || a_dut_a !== 2'd3 || a_pass !== 1'b1) begin
            n_fail++; $display("FAIL nor_after got done=%b a=%0d pass=%b exp 0/3/1", a_done, a_dut_a, a_pass); end
    endtask

    task automatic test_broken_gate();
        int cyc;
        a_mode = 2'd1;
        run(0, 3'd0, cyc);
        n_tests++; if (cyc !== (STOP ? 3 : 9)) begin n_fail++; $display("FAIL broken_done_cycle got %0d exp %0d", cyc, STOP ? 3 : 9); end
        n_tests++; if (a_err !== (STOP ? 3'd1 : 3'd2)) begin n_fail++; $display("FAIL broken_err got %0d exp %0d", a_err, STOP ? 1 : 2); end
        n_tests++; if (a_pass !== 1'b0 || a_fail !== 2'd0) begin n_fail++; $display("FAIL broken_pass_fv got %b/%0d exp 0/0", a_pass, a_fail); end
    endtask

    task automatic test_stop_on_fail();
        int cyc;
        a_mode = 2'd2;
        run(0, 3'd3, cyc);
        n_tests++; if (cyc !== (STOP ? 5 : 9)) begin n_fail++; $display("FAIL stuck_done_cycle got %0d exp %0d", cyc, STOP ? 5 : 9); end
        n_tests++; if (a_err !== (STOP ? 3'd1 : 3'd3)) begin n_fail++; $display("FAIL stuck_err got %0d exp %0d", a_err, STOP ? 1 : 3); end
        n_tests++; if (a_fail !== 2'd1 || a_pass !== 1'b0) begin n_fail++; $display("FAIL stuck_fv_pass got %0d/%b exp 1/0", a_fail, a_pass); end
        n_tests++; if (a_dut_a !== (STOP ? 2'd1 : 2'd3)) begin n_fail++; $display("FAIL stuck_dut_a got %0d exp %0d", a_dut_a, STOP ? 1 : 3); end
    endtask

    task automatic test_width_settle();
        int cyc;
        run(1, 3'd4, cyc);
        n_tests++; if (cyc !== 65) begin n_fail++; $display("FAIL xor_done_cycle got %0d exp 65", cyc); end
        n_tests++; if (b_pass !== 1'b1 || b_err !== 5'd0) begin n_fail++; $display("FAIL xor_result got pass=%b err=%0d exp 1/0", b_pass, b_err); end
        run(1, 3'd5, cyc);
        n_tests++; if (b_err !== (STOP ? 5'd1 : 5'd16)) begin n_fail++; $display("FAIL xnor_err got %0d exp %0d", b_err, STOP ? 1 : 16); end
        n_tests++; if (b_fail !== 4'd0 || b_pass !== 1'b0) begin n_fail++; $display("FAIL xnor_fv_pass got %0d/%b exp 0/0", b_fail, b_pass); end
    endtask

    task automatic test_back_to_back();
        int dones = 0, done_at = -1;
        a_mode = 2'd0;
        @(negedge clk);
        a_op = 3'd0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            a_start = (c == 2 || c == 4 || c == 7) ? 1'b1 : 1'b0;
            if (c == 3) a_op = 3'd3;
            if (c == 6) a_op = 3'd2;
            if (a_done) begin dones++; done_at = c; end
            @(negedge clk);
        end
        a_start = 1'b0;
        n_tests++; if (dones !== 1 || done_at !== 9) begin n_fail++; $display("FAIL b2b_dones got %0d at %0d exp 1 at 9", dones, done_at); end
        n_tests++; if (a_pass !== 1'b1 || a_err !== 3'd0) begin n_fail++; $display("FAIL b2b_result got pass=%b err=%0d exp 1/0", a_pass, a_err); end
        // start coinciding with the DONE cycle must be dropped
        a_op = 3'd0;
        run(0, 3'd0, done_at);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (a_busy !== 1'b0 || done_at !== 9) begin n_fail++; $display("FAIL start_in_done got busy=%b cyc=%0d exp 0/9", a_busy, done_at); end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        a_mode = 2'd1;
        @(negedge clk);
        a_op = 3'd0; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++; if (a_dut_a !== 2'd2 || a_err !== 3'd1) begin n_fail++; $display("FAIL pre_reset got a=%0d err=%0d exp 2/1", a_dut_a, a_err); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (a_dut_a !== 2'd0 || a_err !== 3'd0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got a=%0d err=%0d busy=%b done=%b pass=%b exp all 0", a_dut_a, a_err, a_busy, a_done, a_pass); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (a_done || a_busy) dones++;
            @(negedge clk);
        end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL post_reset_activity got %0d exp 0", dones); end
    endtask

    task automatic test_reserved_ops();
        int cyc;
        run(2, 3'd7, cyc);
        n_tests++; if (cyc !== 5 || c_pass !== 1'b1 || c_err !== 2'd0) begin
            n_fail++; $display("FAIL op7_inv got cyc=%0d pass=%b err=%0d exp 5/1/0", cyc, c_pass, c_err); end
        run(2, 3'd1, cyc);
        n_tests++; if (c_pass !== 1'b1 || c_err !== 2'd0) begin n_fail++; $display("FAIL nand_inv got pass=%b err=%0d exp 1/0", c_pass, c_err); end
        run(2, 3'd2, cyc);
        n_tests++; if (c_err !== (STOP ? 2'd1 : 2'd2) || c_fail !== 1'b0) begin
            n_fail++; $display("FAIL and_inv got err=%0d fv=%0d exp %0d/0", c_err, c_fail, STOP ? 1 : 2); end
    endtask

    initial begin
        test_reset();
        test_nor_good();
        test_broken_gate();
        test_stop_on_fail();
        test_width_settle();
        test_back_to_back();
        test_mid_reset();
        test_reserved_ops();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
